// File: rtl/glyph_pkg.sv
// Glyph codes shared by the text-selection logic and the display driver,
// plus the code-to-segment lookup used by the seven-segment decoder.
package glyph_pkg;

    localparam int unsigned GLYPH_W = 5;
    localparam int unsigned SEG_W   = 7;
    localparam int unsigned DIGITS  = 4;
    localparam int unsigned WORD_W  = GLYPH_W * DIGITS;

    localparam logic [GLYPH_W-1:0] GLYPH_0          = 5'd0;
    localparam logic [GLYPH_W-1:0] GLYPH_1          = 5'd1;
    localparam logic [GLYPH_W-1:0] GLYPH_2          = 5'd2;
    localparam logic [GLYPH_W-1:0] GLYPH_3          = 5'd3;
    localparam logic [GLYPH_W-1:0] GLYPH_4          = 5'd4;
    localparam logic [GLYPH_W-1:0] GLYPH_5          = 5'd5;
    localparam logic [GLYPH_W-1:0] GLYPH_6          = 5'd6;
    localparam logic [GLYPH_W-1:0] GLYPH_7          = 5'd7;
    localparam logic [GLYPH_W-1:0] GLYPH_8          = 5'd8;
    localparam logic [GLYPH_W-1:0] GLYPH_9          = 5'd9;
    localparam logic [GLYPH_W-1:0] GLYPH_A          = 5'd10;
    localparam logic [GLYPH_W-1:0] GLYPH_B          = 5'd11;
    localparam logic [GLYPH_W-1:0] GLYPH_C          = 5'd12;
    localparam logic [GLYPH_W-1:0] GLYPH_D          = 5'd13;
    localparam logic [GLYPH_W-1:0] GLYPH_E          = 5'd14;
    localparam logic [GLYPH_W-1:0] GLYPH_F          = 5'd15;
    localparam logic [GLYPH_W-1:0] GLYPH_H          = 5'd16;
    localparam logic [GLYPH_W-1:0] GLYPH_L          = 5'd17;
    localparam logic [GLYPH_W-1:0] GLYPH_N          = 5'd18;
    localparam logic [GLYPH_W-1:0] GLYPH_O          = 5'd19;
    localparam logic [GLYPH_W-1:0] GLYPH_P          = 5'd20;
    localparam logic [GLYPH_W-1:0] GLYPH_R          = 5'd21;
    localparam logic [GLYPH_W-1:0] GLYPH_T          = 5'd22;
    localparam logic [GLYPH_W-1:0] GLYPH_U          = 5'd23;
    localparam logic [GLYPH_W-1:0] GLYPH_Y          = 5'd24;
    localparam logic [GLYPH_W-1:0] GLYPH_DASH       = 5'd25;
    localparam logic [GLYPH_W-1:0] GLYPH_UNDERSCORE = 5'd26;
    localparam logic [GLYPH_W-1:0] GLYPH_BLANK      = 5'd31;

    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

    // Active-low {g,f,e,d,c,b,a}; codes 27..30 are unassigned and stay dark.
    function automatic logic [SEG_W-1:0] glyph_seg(input logic [GLYPH_W-1:0] code);
        logic [SEG_W-1:0] s;
        s = SEG_BLANK;
        case (code)
            GLYPH_0:          s = 7'h40;
            GLYPH_1:          s = 7'h79;
            GLYPH_2:          s = 7'h24;
            GLYPH_3:          s = 7'h30;
            GLYPH_4:          s = 7'h19;
            GLYPH_5:          s = 7'h12;
            GLYPH_6:          s = 7'h02;
            GLYPH_7:          s = 7'h78;
            GLYPH_8:          s = 7'h00;
            GLYPH_9:          s = 7'h10;
            GLYPH_A:          s = 7'h08;
            GLYPH_B:          s = 7'h03;
            GLYPH_C:          s = 7'h46;
            GLYPH_D:          s = 7'h21;
            GLYPH_E:          s = 7'h06;
            GLYPH_F:          s = 7'h0E;
            GLYPH_H:          s = 7'h09;
            GLYPH_L:          s = 7'h47;
            GLYPH_N:          s = 7'h2B;
            GLYPH_O:          s = 7'h23;
            GLYPH_P:          s = 7'h0C;
            GLYPH_R:          s = 7'h2F;
            GLYPH_T:          s = 7'h07;
            GLYPH_U:          s = 7'h41;
            GLYPH_Y:          s = 7'h11;
            GLYPH_DASH:       s = 7'h3F;
            GLYPH_UNDERSCORE: s = 7'h77;
            default:          s = SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/glyph_scan_if.sv
// Glyph word input and display-pin bundle between the text logic (master)
// and the scanning display driver (slave).
interface glyph_scan_if;
    import glyph_pkg::*;

    logic [WORD_W-1:0] glyph_word;
    logic              load;
    logic              blink_en;
    logic [DIGITS-1:0] an;
    logic [SEG_W-1:0]  seg;
    logic              frame_done;
    logic              pending;

    modport master (
        output glyph_word, load, blink_en,
        input  an, seg, frame_done, pending
    );

    modport slave (
        input  glyph_word, load, blink_en,
        output an, seg, frame_done, pending
    );

endinterface

// File: rtl/glyph_seg_dec.sv
// Combinational 5-bit glyph code to active-low seven-segment decoder.
module glyph_seg_dec
    import glyph_pkg::*;
(
    input  logic [GLYPH_W-1:0] code,
    output logic [SEG_W-1:0]   seg
);

    assign seg = glyph_seg(code);

endmodule

// File: rtl/glyph_scan.sv
// Four-digit common-anode scan driver: round-robin digit slots, frame-aligned
// word updates so the display never tears, and optional whole-display blink.
module glyph_scan
    import glyph_pkg::*;
#(
    parameter int unsigned SCAN_DIV     = 100000,
    parameter int unsigned BLINK_FRAMES = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    glyph_scan_if.slave  bus
);

    localparam int unsigned TICK_W  = $clog2(SCAN_DIV);
    localparam int unsigned BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [WORD_W-1:0] WORD_BLANK = '1;

    logic [TICK_W-1:0]  tick_q, tick_d;
    logic [1:0]         idx_q, idx_d;
    logic [WORD_W-1:0]  pend_word_q, pend_word_d;
    logic               pend_flag_q, pend_flag_d;
    logic [WORD_W-1:0]  act_word_q, act_word_d;
    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic               blink_phase_q, blink_phase_d;
    logic [DIGITS-1:0]  an_q, an_d;
    logic [SEG_W-1:0]   seg_q, seg_d;
    logic               frame_done_q, frame_done_d;

    logic               tick_wrap;
    logic               boundary;
    logic [GLYPH_W-1:0] slot_code;
    logic [SEG_W-1:0]   dec_seg;

    always_comb begin
        slot_code = GLYPH_BLANK;
        case (idx_q)
            2'd0:    slot_code = act_word_q[19:15];
            2'd1:    slot_code = act_word_q[14:10];
            2'd2:    slot_code = act_word_q[9:5];
            default: slot_code = act_word_q[4:0];
        endcase
    end

    glyph_seg_dec u_dec (
        .code (slot_code),
        .seg  (dec_seg)
    );

    always_comb begin
        tick_wrap     = (tick_q == TICK_W'(SCAN_DIV - 1));
        boundary      = tick_wrap && (idx_q == 2'd3);

        tick_d        = tick_wrap ? '0 : tick_q + TICK_W'(1);
        idx_d         = idx_q;
        pend_word_d   = pend_word_q;
        pend_flag_d   = pend_flag_q;
        act_word_d    = act_word_q;
        blink_cnt_d   = blink_cnt_q;
        blink_phase_d = blink_phase_q;
        frame_done_d  = boundary;

        if (tick_wrap) begin
            idx_d = idx_q + 2'd1;
        end

        if (bus.load) begin
            pend_word_d = bus.glyph_word;
            pend_flag_d = 1'b1;
        end

        // A load landing on the boundary cycle stays pending for the next frame.
        if (boundary) begin
            if (pend_flag_q) begin
                act_word_d = pend_word_q;
            end
            if (!bus.load) begin
                pend_flag_d = 1'b0;
            end
            if (blink_cnt_q == BLINK_W'(BLINK_FRAMES - 1)) begin
                blink_cnt_d   = '0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + BLINK_W'(1);
            end
        end

        // First tick of each slot keeps all anodes off to avoid ghosting.
        an_d  = (tick_q == '0) ? 4'b1111 : ~(4'b1000 >> idx_q);
        seg_d = (bus.blink_en && blink_phase_q) ? SEG_BLANK : dec_seg;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tick_q        <= '0;
            idx_q         <= '0;
            pend_word_q   <= WORD_BLANK;
            pend_flag_q   <= 1'b0;
            act_word_q    <= WORD_BLANK;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            an_q          <= 4'b1111;
            seg_q         <= SEG_BLANK;
            frame_done_q  <= 1'b0;
        end else begin
            tick_q        <= tick_d;
            idx_q         <= idx_d;
            pend_word_q   <= pend_word_d;
            pend_flag_q   <= pend_flag_d;
            act_word_q    <= act_word_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            an_q          <= an_d;
            seg_q         <= seg_d;
            frame_done_q  <= frame_done_d;
        end
    end

    assign bus.an         = an_q;
    assign bus.seg        = seg_q;
    assign bus.frame_done = frame_done_q;
    assign bus.pending    = pend_flag_q;

endmodule

// File: tb/tb_glyph_scan.sv
// Directed bench for glyph_scan with SCAN_DIV=4 (16-cycle frames) and BLINK_FRAMES=2.
module tb_glyph_scan;

    logic clk;
    logic rst_n;
    int   cyc;
    int   total;
    int   passed;

    glyph_scan_if gi ();

    glyph_scan #(
        .SCAN_DIV     (4),
        .BLINK_FRAMES (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (gi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edges since reset release; outputs after edge c reflect scan state c-1.
    always @(posedge clk) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic goto(input int c);
        int k;
        k = 0;
        while (cyc != c && k < 1000) begin
            step();
            k++;
        end
        if (cyc != c) begin
            total++;
            $display("FAIL goto: cycle %0d reached, wanted %0d", cyc, c);
        end
    endtask

    task automatic do_load(input logic [19:0] w);
        gi.glyph_word = w;
        gi.load = 1'b1;
        step();
        gi.load = 1'b0;
    endtask

    task automatic test_reset();
        int  fd_at;
        bit  lit;
        rst_n = 1'b0;
        repeat (3) step();
        total++;
        if ({gi.an, gi.seg, gi.frame_done, gi.pending} !== {4'b1111, 7'h7F, 1'b0, 1'b0}) begin
            $display("FAIL reset_hold: got an=%b seg=%h fd=%b pend=%b", gi.an, gi.seg,
                     gi.frame_done, gi.pending);
        end else passed++;
        rst_n = 1'b1;
        step();
        total++;
        if (gi.an !== 4'b1111 || gi.seg !== 7'h7F) begin
            $display("FAIL reset_first: got an=%b seg=%h want 1111/7f", gi.an, gi.seg);
        end else passed++;
        fd_at = -1;
        lit = 1'b0;
        while (fd_at < 0 && cyc < 40) begin
            if (gi.frame_done === 1'b1) fd_at = cyc;
            if (gi.seg !== 7'h7F) lit = 1'b1;
            if (fd_at < 0) step();
        end
        total++;
        if (fd_at != 16) $display("FAIL first_frame_done: at cycle %0d want 16", fd_at);
        else passed++;
        total++;
        if (lit) $display("FAIL reset_blank: seg lit before first load, want 7f");
        else passed++;
        step();
        total++;
        if (gi.frame_done !== 1'b0) $display("FAIL frame_done_width: got %b want 0", gi.frame_done);
        else passed++;
    endtask

    task automatic test_load();
        goto(20);
        do_load({5'd1, 5'd2, 5'd3, 5'd4});
        total++;
        if (gi.pending !== 1'b1) $display("FAIL pending_rise: got %b want 1", gi.pending);
        else passed++;
        goto(31);
        total++;
        if (gi.pending !== 1'b1 || gi.seg !== 7'h7F) begin
            $display("FAIL pending_hold: got pend=%b seg=%h want 1/7f", gi.pending, gi.seg);
        end else passed++;
        goto(32);
        total++;
        if (gi.pending !== 1'b0 || gi.frame_done !== 1'b1) begin
            $display("FAIL pending_fall: got pend=%b fd=%b want 0/1", gi.pending, gi.frame_done);
        end else passed++;
        goto(35);
        total++;
        if ({gi.an, gi.seg} !== {4'b0111, 7'h79}) $display("FAIL slot0: got %b/%h want 0111/79", gi.an, gi.seg);
        else passed++;
        goto(39);
        total++;
        if ({gi.an, gi.seg} !== {4'b1011, 7'h24}) $display("FAIL slot1: got %b/%h want 1011/24", gi.an, gi.seg);
        else passed++;
        goto(43);
        total++;
        if ({gi.an, gi.seg} !== {4'b1101, 7'h30}) $display("FAIL slot2: got %b/%h want 1101/30", gi.an, gi.seg);
        else passed++;
        goto(47);
        total++;
        if ({gi.an, gi.seg} !== {4'b1110, 7'h19}) $display("FAIL slot3: got %b/%h want 1110/19", gi.an, gi.seg);
        else passed++;
    endtask

    task automatic test_back_to_back();
        bit saw5;
        bit bad6;
        goto(49);
        do_load({4{5'd5}});
        goto(53);
        do_load({4{5'd6}});
        saw5 = 1'b0;
        bad6 = 1'b0;
        for (int c = 55; c <= 79; c++) begin
            goto(c);
            if (gi.seg === 7'h12) saw5 = 1'b1;
            if (c >= 67 && (c % 4) == 3 && gi.seg !== 7'h02) bad6 = 1'b1;
        end
        total++;
        if (saw5) $display("FAIL last_wins_5555: digit 5 segments seen, want none");
        else passed++;
        total++;
        if (bad6) $display("FAIL last_wins_6666: a slot did not show 02");
        else passed++;
    endtask

    task automatic test_boundary_load();
        do_load({5'd7, 5'd8, 5'd9, 5'd0});  // sampled on the boundary edge (cycle 80)
        total++;
        if (gi.pending !== 1'b1) $display("FAIL bnd_pending: got %b want 1", gi.pending);
        else passed++;
        goto(83);
        total++;
        if (gi.seg !== 7'h02) $display("FAIL bnd_old_first: got seg=%h want 02", gi.seg);
        else passed++;
        goto(95);
        total++;
        if ({gi.an, gi.seg} !== {4'b1110, 7'h02}) $display("FAIL bnd_old_last: got %b/%h want 1110/02", gi.an, gi.seg);
        else passed++;
        goto(96);
        total++;
        if (gi.pending !== 1'b0) $display("FAIL bnd_consumed: got %b want 0", gi.pending);
        else passed++;
        goto(99);
        total++;
        if (gi.seg !== 7'h78) $display("FAIL bnd_new0: got %h want 78", gi.seg);
        else passed++;
        goto(103);
        total++;
        if (gi.seg !== 7'h00) $display("FAIL bnd_new1: got %h want 00", gi.seg);
        else passed++;
        goto(107);
        total++;
        if (gi.seg !== 7'h10) $display("FAIL bnd_new2: got %h want 10", gi.seg);
        else passed++;
        goto(111);
        total++;
        if (gi.seg !== 7'h40) $display("FAIL bnd_new3: got %h want 40", gi.seg);
        else passed++;
    endtask

    task automatic test_decode_antighost();
        int  off_cnt;
        bit  off_bad;
        goto(115);
        do_load({5'd27, 5'd10, 5'd31, 5'd23});
        off_cnt = 0;
        off_bad = 1'b0;
        for (int c = 129; c <= 144; c++) begin
            goto(c);
            if (gi.an === 4'b1111) begin
                off_cnt++;
                if (((c - 1) % 4) != 0) off_bad = 1'b1;
            end
            if (c == 131) begin
                total++;
                if ({gi.an, gi.seg} !== {4'b0111, 7'h7F}) $display("FAIL undef27: got %b/%h want 0111/7f", gi.an, gi.seg);
                else passed++;
            end
            if (c == 135) begin
                total++;
                if (gi.seg !== 7'h08) $display("FAIL letter_a: got %h want 08", gi.seg);
                else passed++;
            end
            if (c == 139) begin
                total++;
                if (gi.seg !== 7'h7F) $display("FAIL blank31: got %h want 7f", gi.seg);
                else passed++;
            end
            if (c == 143) begin
                total++;
                if (gi.seg !== 7'h41) $display("FAIL letter_u: got %h want 41", gi.seg);
                else passed++;
            end
        end
        total++;
        if (off_cnt != 4 || off_bad) $display("FAIL antighost: %0d off cycles (misplaced=%b) want 4", off_cnt, off_bad);
        else passed++;
    endtask

    task automatic test_blink();
        bit lit;
        gi.blink_en = 1'b1;
        goto(151);
        total++;
        if ({gi.an, gi.seg} !== {4'b1011, 7'h08}) $display("FAIL blink_visible: got %b/%h want 1011/08", gi.an, gi.seg);
        else passed++;
        goto(160);
        total++;
        if (gi.frame_done !== 1'b1) $display("FAIL blink_fd: got %b want 1", gi.frame_done);
        else passed++;
        lit = 1'b0;
        for (int c = 161; c <= 176; c++) begin
            goto(c);
            if (gi.seg !== 7'h7F) lit = 1'b1;
        end
        total++;
        if (lit) $display("FAIL blink_dark: segments lit in blank frame, want 7f");
        else passed++;
        goto(179);
        total++;
        if (gi.seg !== 7'h7F) $display("FAIL blink_dark2: got %h want 7f", gi.seg);
        else passed++;
        goto(181);
        gi.blink_en = 1'b0;
        step();
        total++;
        if ({gi.an, gi.seg} !== {4'b1011, 7'h08}) $display("FAIL blink_release: got %b/%h want 1011/08", gi.an, gi.seg);
        else passed++;
    endtask

    task automatic test_reset_mid();
        bit lit;
        int fd_seen;
        goto(185);
        do_load({4{5'd1}});
        total++;
        if (gi.pending !== 1'b1) $display("FAIL rst_pre_pending: got %b want 1", gi.pending);
        else passed++;
        rst_n = 1'b0;
        step();
        total++;
        if ({gi.an, gi.seg, gi.frame_done, gi.pending} !== {4'b1111, 7'h7F, 1'b0, 1'b0}) begin
            $display("FAIL rst_mid: got an=%b seg=%h fd=%b pend=%b", gi.an, gi.seg,
                     gi.frame_done, gi.pending);
        end else passed++;
        step();
        rst_n = 1'b1;
        lit = 1'b0;
        fd_seen = 0;
        for (int c = 1; c <= 36; c++) begin
            goto(c);
            if (gi.seg !== 7'h7F || gi.pending !== 1'b0) lit = 1'b1;
            if (gi.frame_done === 1'b1) fd_seen = c;
        end
        total++;
        if (lit) $display("FAIL rst_discard: pending word survived reset");
        else passed++;
        total++;
        if (fd_seen != 32) $display("FAIL rst_frame: last frame_done at %0d want 32", fd_seen);
        else passed++;
    endtask

    initial begin
        total = 0;
        passed = 0;
        rst_n = 1'b0;
        gi.glyph_word = '0;
        gi.load = 1'b0;
        gi.blink_en = 1'b0;
        test_reset();
        test_load();
        test_back_to_back();
        test_boundary_load();
        test_decode_antighost();
        test_blink();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/glyph_scan.md
# glyph_scan

Time-multiplexed driver for the 4-digit common-anode seven-segment display. Consumes the packed 20-bit glyph word (four 5-bit glyph codes, leftmost digit in bits 19:15) that the menu/help text logic produces. Decodes each code to segments, scans digits round-robin, and applies a new word only at a frame boundary so the display never tears. Optional whole-display blink. Sits between the state-driven text selection and the board display pins.

## Interface

- SCAN_DIV, 100000: clk cycles per digit slot (≥4)
- BLINK_FRAMES, 64: frames per blink half-period (≥1)
- clk  in  1  system clock
- rst_n  in  1  synchronous, active-low reset
- glyph_word  in  20  four 5-bit glyph codes; [19:15] leftmost … [4:0] rightmost
- load  in  1  one-cycle strobe; capture glyph_word as pending
- blink_en  in  1  level; enables blinking of the whole display
- an  out  4  digit enables, active-low; an[3] leftmost
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low
- frame_done  out  1  one-cycle pulse at each frame boundary
- pending  out  1  high while a captured word awaits its frame boundary

## Operation

- Registers: tick (0..SCAN_DIV-1), idx (0..3), pend_word, pend_flag, act_word, blink_cnt (0..BLINK_FRAMES-1), blink_phase.
- tick increments every cycle and wraps at SCAN_DIV-1. On wrap idx increments; 3→0 is a frame boundary.
- Slot idx shows act_word[19-5*idx -: 5] on an[3-idx]. idx 0 = leftmost.
- load: pend_word ← glyph_word, pend_flag ← 1. A second load before the boundary overwrites pend_word (last wins).
- Frame boundary: if pend_flag, act_word ← pend_word and pend_flag ← 0. If load coincides with the boundary cycle, the new word goes to pend_word and is applied at the following boundary, not this one.
- Blink: at each boundary blink_cnt advances and wraps at BLINK_FRAMES-1. On wrap, blink_phase toggles. With blink_en=1 and blink_phase=1, all slots are blanked. blink_en=0 forces visible output but does not stop the counter.
- Anti-ghost: during tick==0 of every slot, an=4'b1111.
- Decode: codes 0–9 map to decimal digits, 31 to blank (seg=7'h7F), and the others to letter glyphs from the shared glyph table. Undefined codes decode as blank.

## Timing

- Reset values: tick=0, idx=0, pend_flag=0, pend_word=act_word=20'hFFFFF (all blank), blink_cnt=0, blink_phase=0. Outputs: an=4'b1111, seg=7'h7F, frame_done=0, pending=0.
- an and seg are registered, one cycle after tick/idx/act_word. Slot n enables an[3-n] low from tick==1 to SCAN_DIV-1 (seen on outputs one cycle later).
- frame_done is registered and high for exactly one cycle, the cycle after the idx 3→0 transition.
- pending goes high the cycle after load and low the cycle after the boundary that consumes the word.
- Load-to-visible latency: at most 4·SCAN_DIV+2 cycles.
- Reset mid-frame: all state returns to reset values on the next clk edge, and any pending word is discarded.

## Structure

- glyph_pkg holds the glyph code constants (GLYPH_BLANK=5'd31, digit and letter codes) and the 32-entry segment lookup function. The text-selection logic shares these constants.
- One sub-module: glyph_seg_dec, a combinational 5-bit code → 7-bit active-low segment decoder using the package table.
- The top level holds only the counters, word registers, blink logic and output registers.

## Test plan

- Reset release with SCAN_DIV=4: an=1111 and seg=7F for the first cycle. The first frame_done arrives 16 cycles after release. The display stays blank.
- load glyph_word={5'd1,5'd2,5'd3,5'd4} mid-frame: pending=1 until the boundary. From the next frame, an[3] shows seg "1", then an[2]="2", an[1]="3", an[0]="4".
- Two loads in one frame (digits 5555, then 6666): only 6666 appears and 5555 is never displayed.
- load exactly on the boundary cycle: the old word is shown for one more full frame, then the new word.
- blink_en=1, BLINK_FRAMES=2: all segments are blank for frames 2–3, 6–7, and so on. Deasserting blink_en restores the display in the next slot.
- Anti-ghost check: in every slot, an=1111 for exactly one cycle. Code 5'd27 (undefined) drives seg=7F. Asserting rst_n=0 mid-frame gives reset outputs next cycle and drops pending.
